// File: rtl/avalon_2to1_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : avalon_2to1_arbiter
// Purpose  : Shares one Avalon slave port (the Avalon-to-AXI3 bridge) between
//            two Avalon masters. Arbitration is registered (one IDLE cycle
//            per unlocked grant), round-robin or fixed priority, with a lock
//            that holds the grant across an atomic sequence. Read data is
//            routed back to its requester by a small in-order owner FIFO.
// Ports    : ACLK, ARESETN          clock, synchronous active-low reset
//            m0_* / m1_*            master-side Avalon ports (0 and 1)
//            s_*                    muxed Avalon command to the bridge and the
//                                   bridge's response/handshake inputs
//            err_unexpected_rdv     sticky: read data seen with no owner queued
// Revision : 1.0 - initial release
// =============================================================================
module avalon_2to1_arbiter #(
  parameter int PRIORITY    = 0,  // 0 = round-robin, 1 = fixed (port 0 wins)
  parameter int MAX_PENDING = 2   // outstanding reads, 1..4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  // master 0
  input  logic [31:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic        m0_lock,
  output logic [31:0] m0_readdata,
  output logic [1:0]  m0_response,
  output logic        m0_waitrequest,
  output logic        m0_readdatavalid,
  // master 1
  input  logic [31:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic        m1_lock,
  output logic [31:0] m1_readdata,
  output logic [1:0]  m1_response,
  output logic        m1_waitrequest,
  output logic        m1_readdatavalid,
  // bridge side
  output logic [31:0] s_address,
  output logic [3:0]  s_byteenable,
  output logic [31:0] s_writedata,
  output logic        s_read,
  output logic        s_write,
  output logic        s_lock,
  input  logic [31:0] s_readdata,
  input  logic [1:0]  s_response,
  input  logic        s_waitrequest,
  input  logic        s_readdatavalid,
  output logic        err_unexpected_rdv
);

  localparam int c_CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [c_CNT_W-1:0]     c_MAX = c_CNT_W'(MAX_PENDING);
  localparam logic [MAX_PENDING-1:0] c_ONE = MAX_PENDING'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                   r_state;
  logic                     r_gnt;
  logic                     r_last_gnt;
  logic                     r_err;
  logic [c_CNT_W-1:0]       r_count;
  // Owner FIFO as a shift register: bit 0 is the head (oldest read).
  logic [MAX_PENDING-1:0]   r_owner;

  logic                     w_req0;
  logic                     w_req1;
  logic                     w_granted;
  logic                     w_sel;
  logic                     w_g_read;
  logic                     w_g_write;
  logic                     w_g_lock;
  logic                     w_g_req;
  logic                     w_full;
  logic                     w_blocked;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_winner;
  logic [c_CNT_W-1:0]       w_count_nxt;
  logic [c_CNT_W-1:0]       w_wr_idx;
  logic [MAX_PENDING-1:0]   w_mask;
  logic [MAX_PENDING-1:0]   w_owner_shift;
  logic [MAX_PENDING-1:0]   w_owner_nxt;

  assign w_req0    = m0_read | m0_write;
  assign w_req1    = m1_read | m1_write;
  assign w_granted = (r_state == ST_GRANT);

  // In IDLE the mux parks on port 0; strobes are gated separately below.
  assign w_sel     = w_granted & r_gnt;
  assign w_g_read  = w_sel ? m1_read  : m0_read;
  assign w_g_write = w_sel ? m1_write : m0_write;
  assign w_g_lock  = w_sel ? m1_lock  : m0_lock;
  assign w_g_req   = w_g_read | w_g_write;

  // A read with every owner slot taken is held off at the master, and never
  // reaches the bridge, until read data frees a slot.
  assign w_full    = (r_count == c_MAX);
  assign w_blocked = w_granted & w_g_read & w_full;

  // --------------------------------------------------------------------------
  // Command path to the bridge
  // --------------------------------------------------------------------------
  assign s_address    = w_sel ? m1_address    : m0_address;
  assign s_byteenable = w_sel ? m1_byteenable : m0_byteenable;
  assign s_writedata  = w_sel ? m1_writedata  : m0_writedata;
  assign s_read       = w_granted & w_g_read & ~w_full;
  assign s_write      = w_granted & w_g_write;
  assign s_lock       = w_granted & w_g_lock;

  assign w_accept = (s_read | s_write) & ~s_waitrequest;
  assign w_push   = w_accept & s_read;
  assign w_pop    = s_readdatavalid & (r_count != '0);

  assign m0_waitrequest = (w_granted & ~r_gnt) ? (s_waitrequest | w_blocked) : 1'b1;
  assign m1_waitrequest = (w_granted &  r_gnt) ? (s_waitrequest | w_blocked) : 1'b1;

  // --------------------------------------------------------------------------
  // Response path: pass-through, strobe steered by the FIFO head
  // --------------------------------------------------------------------------
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_response      = s_response;
  assign m1_response      = s_response;
  assign m0_readdatavalid = w_pop & ~r_owner[0];
  assign m1_readdatavalid = w_pop &  r_owner[0];

  assign err_unexpected_rdv = r_err;

  // --------------------------------------------------------------------------
  // Arbitration: single requester always wins; on a tie, round-robin gives
  // the port that was not granted last, fixed priority gives port 0.
  // --------------------------------------------------------------------------
  always_comb begin
    w_winner = w_req1;
    if (w_req0 && w_req1) begin
      w_winner = (PRIORITY == 1) ? 1'b0 : ~r_last_gnt;
    end
  end

  // --------------------------------------------------------------------------
  // Owner FIFO next state. A pop shifts everything toward the head first, so
  // a simultaneous push lands one slot lower than it would on its own.
  // --------------------------------------------------------------------------
  always_comb begin
    w_owner_shift = w_pop ? (r_owner >> 1) : r_owner;
    w_wr_idx      = r_count - c_CNT_W'(w_pop);
    w_mask        = c_ONE << w_wr_idx;
    w_owner_nxt   = w_owner_shift;
    if (w_push) begin
      w_owner_nxt = (w_owner_shift & ~w_mask) | (w_mask & {MAX_PENDING{r_gnt}});
    end
    w_count_nxt   = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
  end

  // --------------------------------------------------------------------------
  // Control FSM and state registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;   // port 0 wins the first round-robin tie
      r_count    <= '0;
      r_owner    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_owner <= w_owner_nxt;
      if (s_readdatavalid && (r_count == '0)) begin
        r_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_req0 | w_req1) begin
            r_gnt   <= w_winner;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // The grant only moves on an accepted transfer or when the granted
          // master has gone quiet, so a stalled command is never torn away.
          if (w_accept) begin
            if (!w_g_lock) begin
              r_state    <= ST_IDLE;
              r_last_gnt <= r_gnt;
            end
          end else if (!w_g_req && !w_g_lock) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_2to1_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_avalon_2to1_arbiter
// Purpose  : Self-checking bench. Instance 0 is round-robin, instance 1 is
//            fixed priority, both with MAX_PENDING = 2. A queue-based model of
//            the arbiter is checked against both instances every cycle;
//            directed sequences add literal expectations.
// Revision : 1.0 - initial release
// =============================================================================
module tb_avalon_2to1_arbiter;

  localparam int MAXP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  // [instance][port]
  logic [31:0] addr[2][2];
  logic [31:0] wd[2][2];
  logic [3:0]  be[2][2];
  logic        rd[2][2];
  logic        wr[2][2];
  logic        lk[2][2];
  logic [31:0] rdata[2][2];
  logic [1:0]  resp[2][2];
  logic        wrq[2][2];
  logic        rdvo[2][2];
  // [instance]
  logic [31:0] s_addr[2];
  logic [31:0] s_wd[2];
  logic [3:0]  s_be[2];
  logic        s_rd[2];
  logic        s_wr[2];
  logic        s_lk[2];
  logic [31:0] s_rdata[2];
  logic [1:0]  s_resp[2];
  logic        s_wait[2];
  logic        s_rdv[2];
  logic        err[2];

  avalon_2to1_arbiter #(.PRIORITY(0), .MAX_PENDING(MAXP)) u_rr (
    .ACLK(clk), .ARESETN(rstn),
    .m0_address(addr[0][0]), .m0_byteenable(be[0][0]), .m0_read(rd[0][0]),
    .m0_write(wr[0][0]), .m0_writedata(wd[0][0]), .m0_lock(lk[0][0]),
    .m0_readdata(rdata[0][0]), .m0_response(resp[0][0]),
    .m0_waitrequest(wrq[0][0]), .m0_readdatavalid(rdvo[0][0]),
    .m1_address(addr[0][1]), .m1_byteenable(be[0][1]), .m1_read(rd[0][1]),
    .m1_write(wr[0][1]), .m1_writedata(wd[0][1]), .m1_lock(lk[0][1]),
    .m1_readdata(rdata[0][1]), .m1_response(resp[0][1]),
    .m1_waitrequest(wrq[0][1]), .m1_readdatavalid(rdvo[0][1]),
    .s_address(s_addr[0]), .s_byteenable(s_be[0]), .s_writedata(s_wd[0]),
    .s_read(s_rd[0]), .s_write(s_wr[0]), .s_lock(s_lk[0]),
    .s_readdata(s_rdata[0]), .s_response(s_resp[0]),
    .s_waitrequest(s_wait[0]), .s_readdatavalid(s_rdv[0]),
    .err_unexpected_rdv(err[0])
  );

  avalon_2to1_arbiter #(.PRIORITY(1), .MAX_PENDING(MAXP)) u_fx (
    .ACLK(clk), .ARESETN(rstn),
    .m0_address(addr[1][0]), .m0_byteenable(be[1][0]), .m0_read(rd[1][0]),
    .m0_write(wr[1][0]), .m0_writedata(wd[1][0]), .m0_lock(lk[1][0]),
    .m0_readdata(rdata[1][0]), .m0_response(resp[1][0]),
    .m0_waitrequest(wrq[1][0]), .m0_readdatavalid(rdvo[1][0]),
    .m1_address(addr[1][1]), .m1_byteenable(be[1][1]), .m1_read(rd[1][1]),
    .m1_write(wr[1][1]), .m1_writedata(wd[1][1]), .m1_lock(lk[1][1]),
    .m1_readdata(rdata[1][1]), .m1_response(resp[1][1]),
    .m1_waitrequest(wrq[1][1]), .m1_readdatavalid(rdvo[1][1]),
    .s_address(s_addr[1]), .s_byteenable(s_be[1]), .s_writedata(s_wd[1]),
    .s_read(s_rd[1]), .s_write(s_wr[1]), .s_lock(s_lk[1]),
    .s_readdata(s_rdata[1]), .s_response(s_resp[1]),
    .s_waitrequest(s_wait[1]), .s_readdatavalid(s_rdv[1]),
    .err_unexpected_rdv(err[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input int k, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL inst%0d %s: actual=%0h required=%0h", k, nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: granted flag, owner, last winner, sticky error and a
  // queue of read owners per instance.
  // ---------------------------------------------------------------------------
  bit mg[2];
  bit mo[2];
  bit ml[2];
  bit me[2];
  bit mq[2][$];
  bit mvalid = 1'b0;
  bit stl[2][2];

  always @(negedge clk) begin
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_rd, e_wr, e_lk, e_blk, e_acc;
    logic        e_wq[2];
    logic        e_rv[2];
    logic        rq[2];
    int          g;
    for (int k = 0; k < 2; k++) begin
      g = int'(mo[k]);
      rq[0] = rd[k][0] | wr[k][0];
      rq[1] = rd[k][1] | wr[k][1];
      e_wq[0] = 1'b1; e_wq[1] = 1'b1;
      e_rd = 1'b0; e_wr = 1'b0; e_lk = 1'b0; e_blk = 1'b0;
      e_addr = addr[k][0]; e_be = be[k][0]; e_wd = wd[k][0];
      if (mg[k]) begin
        e_blk   = rd[k][g] && (mq[k].size() == MAXP);
        e_addr  = addr[k][g]; e_be = be[k][g]; e_wd = wd[k][g];
        e_rd    = rd[k][g] && !e_blk;
        e_wr    = wr[k][g];
        e_lk    = lk[k][g];
        e_wq[g] = s_wait[k] || e_blk;
      end
      e_rv[0] = 1'b0; e_rv[1] = 1'b0;
      if (s_rdv[k] && mq[k].size() > 0) e_rv[int'(mq[k][0])] = 1'b1;

      if (mvalid) begin
        chk(k, "s_read", s_rd[k], e_rd);
        chk(k, "s_write", s_wr[k], e_wr);
        chk(k, "s_lock", s_lk[k], e_lk);
        chk(k, "s_address", s_addr[k], e_addr);
        chk(k, "s_byteenable", s_be[k], e_be);
        chk(k, "s_writedata", s_wd[k], e_wd);
        chk(k, "err_unexpected_rdv", err[k], me[k]);
        for (int x = 0; x < 2; x++) begin
          chk(k, x ? "m1_waitrequest" : "m0_waitrequest", wrq[k][x], e_wq[x]);
          chk(k, x ? "m1_readdatavalid" : "m0_readdatavalid", rdvo[k][x], e_rv[x]);
          chk(k, x ? "m1_readdata" : "m0_readdata", rdata[k][x], s_rdata[k]);
          chk(k, x ? "m1_response" : "m0_response", resp[k][x], s_resp[k]);
          if (rdvo[k][x])
            chk(k, x ? "m1 data tag" : "m0 data tag", rdata[k][x],
                x ? 32'h22222222 : 32'h11111111);
        end
      end

      for (int x = 0; x < 2; x++) stl[k][x] = (rd[k][x] | wr[k][x]) & wrq[k][x];

      if (!rstn) begin
        mg[k] = 1'b0; mo[k] = 1'b0; ml[k] = 1'b1; me[k] = 1'b0;
        mq[k].delete();
      end else begin
        e_acc = (e_rd || e_wr) && !s_wait[k];
        if (s_rdv[k]) begin
          if (mq[k].size() > 0) void'(mq[k].pop_front());
          else me[k] = 1'b1;
        end
        if (e_acc && e_rd) mq[k].push_back(mo[k]);
        if (!mg[k]) begin
          if (rq[0] || rq[1]) begin
            mg[k] = 1'b1;
            if (rq[0] && rq[1]) mo[k] = (k == 1) ? 1'b0 : !ml[k];
            else mo[k] = rq[1];
          end
        end else if (e_acc) begin
          if (!lk[k][g]) begin mg[k] = 1'b0; ml[k] = mo[k]; end
        end else if (!rq[g] && !lk[k][g]) begin
          mg[k] = 1'b0;
        end
      end
    end
    if (!rstn) mvalid = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit rand_mode = 1'b0;
  int rdv_pct   = 0;
  bit force_rdv[2];

  task automatic drive_bridge();
    for (int k = 0; k < 2; k++) begin
      s_rdv[k]  = force_rdv[k] ||
                  (mq[k].size() > 0 && ($urandom_range(0, 99) < rdv_pct));
      s_rdata[k] = (mq[k].size() > 0) ? (mq[k][0] ? 32'h22222222 : 32'h11111111)
                                      : $urandom;
      s_resp[k]  = 2'($urandom_range(0, 3));
      if (rand_mode) begin
        s_wait[k] = ($urandom_range(0, 3) == 0);
        for (int x = 0; x < 2; x++) begin
          if (!stl[k][x]) begin
            int c;
            c = $urandom_range(0, 9);
            rd[k][x]   = (c < 4);
            wr[k][x]   = (c >= 4 && c < 7);
            lk[k][x]   = (c < 7) && ($urandom_range(0, 4) == 0);
            addr[k][x] = $urandom;
            wd[k][x]   = $urandom;
            be[k][x]   = 4'($urandom_range(0, 15));
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_bridge();
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++)
      for (int x = 0; x < 2; x++) begin
        rd[k][x] = 1'b0; wr[k][x] = 1'b0; lk[k][x] = 1'b0;
      end
  endtask

  initial begin
    int acc[2][2];
    int prev, port, alt_err, early;
    bit got;
    int nacc;

    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      force_rdv[k] = 1'b0; s_wait[k] = 1'b0; s_rdv[k] = 1'b0;
      s_rdata[k] = '0; s_resp[k] = '0;
      for (int x = 0; x < 2; x++) begin
        rd[k][x] = 1'b0; wr[k][x] = 1'b0; lk[k][x] = 1'b0;
        addr[k][x] = 32'h100 * (x + 1); wd[k][x] = '0; be[k][x] = 4'hF;
      end
    end
    repeat (3) tick();
    rstn = 1'b1;

    // Reset state
    smp();
    for (int k = 0; k < 2; k++) begin
      chk(k, "reset m0_waitrequest", wrq[k][0], 1'b1);
      chk(k, "reset m1_waitrequest", wrq[k][1], 1'b1);
      chk(k, "reset s_read", s_rd[k], 1'b0);
      chk(k, "reset s_write", s_wr[k], 1'b0);
      chk(k, "reset s_lock", s_lk[k], 1'b0);
      chk(k, "reset m0_readdatavalid", rdvo[k][0], 1'b0);
      chk(k, "reset err", err[k], 1'b0);
      chk(k, "model last_gnt at reset", ml[k], 1'b1);
    end

    // Single write on an idle arbiter
    tick();
    wr[0][0] = 1'b1; addr[0][0] = 32'h1000; wd[0][0] = 32'hDEADBEEF; be[0][0] = 4'hF;
    smp();
    chk(0, "write cycle n s_write", s_wr[0], 1'b0);
    chk(0, "write cycle n m0_waitrequest", wrq[0][0], 1'b1);
    tick();
    smp();
    chk(0, "write n+1 s_write", s_wr[0], 1'b1);
    chk(0, "write n+1 s_address", s_addr[0], 32'h1000);
    chk(0, "write n+1 s_writedata", s_wd[0], 32'hDEADBEEF);
    chk(0, "write n+1 s_byteenable", s_be[0], 4'hF);
    chk(0, "write n+1 m0_waitrequest", wrq[0][0], 1'b0);
    chk(0, "write n+1 m1_waitrequest", wrq[0][1], 1'b1);
    chk(0, "model granted after write", mg[0], 1'b0);
    chk(0, "model last_gnt after write", ml[0], 1'b0);
    tick();
    wr[0][0] = 1'b0;
    smp();
    chk(0, "write n+2 s_write", s_wr[0], 1'b0);
    chk(0, "write n+2 m0_waitrequest", wrq[0][0], 1'b1);

    // Contention: both masters read continuously on both instances
    tick();
    rdv_pct = 100;
    for (int k = 0; k < 2; k++) begin
      rd[k][0] = 1'b1; rd[k][1] = 1'b1;
      acc[k][0] = 0; acc[k][1] = 0;
    end
    prev = -1; alt_err = 0;
    for (int i = 0; i < 20; i++) begin
      smp();
      for (int k = 0; k < 2; k++) begin
        if (s_rd[k] && !s_wait[k]) begin
          port = !wrq[k][0] ? 0 : (!wrq[k][1] ? 1 : -1);
          if (port >= 0) acc[k][port]++;
          if (k == 0) begin
            if (port == prev) alt_err++;
            prev = port;
          end
        end
      end
      tick();
    end
    idle_all();
    chk(0, "rr grants port0", acc[0][0], 5);
    chk(0, "rr grants port1", acc[0][1], 5);
    chk(0, "rr non-alternating grants", alt_err, 0);
    chk(1, "fixed grants port0", acc[1][0], 10);
    chk(1, "fixed grants port1", acc[1][1], 0);
    repeat (3) tick();

    // Lock: m1 locked read then unlocked write while m0 requests
    rd[0][1] = 1'b1; lk[0][1] = 1'b1; rd[0][0] = 1'b1;
    early = 0; got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      smp();
      if (!wrq[0][0]) early++;
      if (!wrq[0][1] && s_rd[0]) got = 1'b1;
      tick();
    end
    chk(0, "lock read accepted", got, 1'b1);
    rd[0][1] = 1'b0; wr[0][1] = 1'b1; lk[0][1] = 1'b0; wd[0][1] = 32'hCAFE0001;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      smp();
      if (!wrq[0][0]) early++;
      if (!wrq[0][1] && s_wr[0]) got = 1'b1;
      tick();
    end
    chk(0, "lock write accepted", got, 1'b1);
    chk(0, "m0 granted during lock", early, 0);
    wr[0][1] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      smp();
      if (!wrq[0][0]) got = 1'b1;
      tick();
    end
    chk(0, "m0 granted after unlock", got, 1'b1);
    idle_all();
    repeat (3) tick();

    // Pending limit with a stalled return path
    rdv_pct = 0;
    rd[0][0] = 1'b1; lk[0][0] = 1'b1;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      smp();
      if (s_rd[0] && !wrq[0][0]) nacc++;
      tick();
    end
    chk(0, "reads accepted before limit", nacc, 2);
    force_rdv[0] = 1'b1;
    tick();
    smp();
    chk(0, "limit rdv m0_readdatavalid", rdvo[0][0], 1'b1);
    chk(0, "limit still blocked s_read", s_rd[0], 1'b0);
    chk(0, "limit still blocked m0_waitrequest", wrq[0][0], 1'b1);
    tick();
    smp();
    chk(0, "pop+push m0_readdatavalid", rdvo[0][0], 1'b1);
    chk(0, "pop+push s_read", s_rd[0], 1'b1);
    force_rdv[0] = 1'b0;
    tick();
    chk(0, "model count after pop+push", mq[0].size(), 1);
    idle_all();
    rdv_pct = 100;
    repeat (4) tick();

    // Reset mid-read, then spurious read data
    rdv_pct = 0;
    rd[0][0] = 1'b1;
    tick();
    smp();
    chk(0, "pre-reset s_read", s_rd[0], 1'b1);
    tick();
    rd[0][0] = 1'b0;
    rstn = 1'b0;
    force_rdv[0] = 1'b1;
    tick();
    rstn = 1'b1;
    force_rdv[0] = 1'b0;
    smp();
    chk(0, "after reset m0_waitrequest", wrq[0][0], 1'b1);
    chk(0, "after reset m1_waitrequest", wrq[0][1], 1'b1);
    chk(0, "after reset s_read", s_rd[0], 1'b0);
    chk(0, "spurious m0_readdatavalid", rdvo[0][0], 1'b0);
    chk(0, "spurious m1_readdatavalid", rdvo[0][1], 1'b0);
    chk(0, "err before flag", err[0], 1'b0);
    tick();
    smp();
    chk(0, "err flagged", err[0], 1'b1);
    repeat (3) tick();
    smp();
    chk(0, "err sticky", err[0], 1'b1);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;

    // Randomized traffic
    rdv_pct = 40;
    rand_mode = 1'b1;
    repeat (4000) tick();
    rand_mode = 1'b0;
    idle_all();
    for (int k = 0; k < 2; k++) s_wait[k] = 1'b0;
    rdv_pct = 100;
    repeat (10) tick();
    for (int k = 0; k < 2; k++) chk(k, "queue drained", mq[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
